// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory port.
//   mem_size_e  - access size encoding on req_size_i (2'b11 is illegal)
//   lsu_state_e - request FSM states
//   LANE_MASK_* - byte-lane write-enable masks before shifting by address offset
package lsu_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RESP      = 2'b10
    } lsu_state_e;

    localparam logic [3:0] LANE_MASK_B = 4'b0001;
    localparam logic [3:0] LANE_MASK_H = 4'b0011;
    localparam logic [3:0] LANE_MASK_W = 4'b1111;

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half out of a RAM word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//   i_word     - raw 32-bit RAM read word
//   i_offset   - byte offset within the word (addr[1:0])
//   i_size     - access size (mem_size_e encoding)
//   i_unsigned - 1: zero-extend, 0: sign-extend
//   o_data     - right-aligned, extended load data
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // halves are only ever legal at offset 0 or 2
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_size)
            MEM_B:   o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            MEM_H:   o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store adapter between the core request channel and one
// port of a word-addressed RAM with a registered read output.
//   clk_i/rst_ni              - clock, async active-low reset
//   req_valid_i/req_ready_o   - request handshake (ready only in IDLE)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i - request
//   rsp_valid_o/rsp_ready_i   - response handshake, response held until taken
//   rsp_rdata_o, rsp_err_o    - extended load data / access error
//   mem_en_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_rdata_i - RAM port
// One request is in flight at a time. RAM controls are driven combinationally
// from the request in the accepting cycle only; they are zero otherwise.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned DATA_DEPTH = 8192
)(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_en_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [32:0] RANGE_BYTES = 33'(DATA_DEPTH) << 2;

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [32:0] w_off;
    logic        w_in_range;
    logic        w_aligned;
    logic        w_legal;
    logic        w_accept;
    logic        w_mem_en;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_load_data;

    // 33-bit subtraction: a borrow into bit 32 means the address is below BASE_ADDR
    assign w_off      = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};
    assign w_in_range = ~w_off[32] && (w_off < RANGE_BYTES);

    always_comb begin
        w_aligned   = 1'b0;
        w_lane_mask = 4'b0000;
        w_wdata_rep = req_wdata_i;
        case (req_size_i)
            MEM_B: begin
                w_aligned   = 1'b1;
                w_lane_mask = LANE_MASK_B << req_addr_i[1:0];
                w_wdata_rep = {4{req_wdata_i[7:0]}};
            end
            MEM_H: begin
                w_aligned   = ~req_addr_i[0];
                w_lane_mask = LANE_MASK_H << req_addr_i[1:0];
                w_wdata_rep = {2{req_wdata_i[15:0]}};
            end
            MEM_W: begin
                w_aligned   = (req_addr_i[1:0] == 2'b00);
                w_lane_mask = LANE_MASK_W;
            end
            default: ;
        endcase
    end

    assign w_legal  = w_aligned & w_in_range;
    // gating with rst_ni keeps the RAM untouched while reset is held
    assign req_ready_o = rst_ni && (r_state == IDLE);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_mem_en    = w_accept & w_legal;

    assign mem_en_o    = w_mem_en;
    assign mem_we_o    = (w_mem_en & req_we_i) ? w_lane_mask : 4'b0000;
    assign mem_addr_o  = w_mem_en ? {2'b00, w_off[31:2]} : 32'd0;
    assign mem_wdata_o = w_mem_en ? w_wdata_rep : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_state_nxt = (w_legal && !req_we_i) ? LOAD_WAIT : RESP;
            LOAD_WAIT: w_state_nxt = RESP;
            RESP:      if (rsp_ready_i) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    lsu_load_align u_align (
        .i_word     (mem_rdata_i),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // Stores and errors respond with rdata=0; loads overwrite it in LOAD_WAIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_offset   <= 2'b00;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_offset   <= req_addr_i[1:0];
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_rdata    <= 32'd0;
            r_err      <= ~w_legal;
        end else if (r_state == LOAD_WAIT) begin
            r_rdata    <= w_load_data;
        end else if (r_state == RESP && rsp_ready_i) begin
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end
    end

    assign rsp_valid_o = (r_state == RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized + directed bench for lsu_mem_port with a
// byte-array reference model, a response scoreboard and a simple RAM model.
module tb_lsu_mem_port;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 256;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_we_o;

    lsu_mem_port #(.BASE_ADDR(BASE), .DATA_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // RAM port model: synchronous write, registered read
    logic [31:0] ram [0:DEPTH-1];
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) ram[mem_addr_o[7:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            mem_rdata_i <= ram[mem_addr_o[7:0]];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        bit          seen;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [0:4*DEPTH-1];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         stall_req = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        if (sz == 2'b11) return 1'b0;
        if (sz == 2'b01 && a[0]) return 1'b0;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
        return (off >= 0) && (off < 4 * DEPTH);
    endfunction

    // Issue one request, check the RAM-side view of it, and queue the expected response.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int          w, n, off;
        bit          legal;
        exp_t        e;
        logic [31:0] val, exp_wd;
        logic [3:0]  exp_we;
        w = 0;
        @(negedge clk_i);
        while (!req_ready_o && w < 50) begin @(negedge clk_i); w++; end
        if (!req_ready_o) begin
            n_cmp++; n_bad++;
            $display("FAIL req_ready_timeout: got ready=0 expected ready=1 within 50 cycles");
            return;
        end
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
        req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
        #1;
        legal = ref_legal(sz, a);
        n = 1 << sz;
        off = int'(a - BASE);
        e.rdata = 32'd0; e.err = !legal; e.seen = 0;
        e.due = cyc + ((legal && !we) ? 2 : 1);
        if (!legal) begin
            chk("illegal_mem_en", 32'(mem_en_o), 32'd0);
            chk("illegal_mem_we", 32'(mem_we_o), 32'd0);
        end else begin
            chk("mem_en", 32'(mem_en_o), 32'd1);
            chk("mem_addr", mem_addr_o, 32'(off >> 2));
            if (we) begin
                exp_we = 4'(((1 << n) - 1) << a[1:0]);
                for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = wd[8*(b % n) +: 8];
                chk("mem_we", 32'(mem_we_o), 32'(exp_we));
                chk("mem_wdata", mem_wdata_o, exp_wd);
                for (int i = 0; i < n; i++) ref_mem[off + i] = wd[8*i +: 8];
            end else begin
                chk("load_mem_we", 32'(mem_we_o), 32'd0);
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[off + i]) << (8 * i));
                if (!uns && n < 4 && val[8*n - 1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
                e.rdata = val;
            end
        end
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_addr_i = $urandom;
        req_size_i = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin @(negedge clk_i); w++; end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Response monitor / scoreboard
    initial begin : monitor
        int  stall;
        bit  chk_idle;
        stall = 0; chk_idle = 0;
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            if (chk_idle) begin
                chk("idle_after_hs_ready", 32'(req_ready_o), 32'd1);
                chk("idle_after_hs_valid", 32'(rsp_valid_o), 32'd0);
                chk_idle = 0;
            end
            if (!rst_ni) begin
                rsp_ready_i = 1'b0;
            end else if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                    rsp_ready_i = 1'b1;
                end else begin
                    if (!exp_q[0].seen) begin
                        chk("rsp_latency_cycle", 32'(cyc), 32'(exp_q[0].due));
                        exp_q[0].seen = 1;
                        stall = stall_req;
                    end
                    chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
                    chk("rsp_err", 32'(rsp_err_o), 32'(exp_q[0].err));
                    chk("busy_ready_low", 32'(req_ready_o), 32'd0);
                    if (stall > 0) begin
                        rsp_ready_i = 1'b0;
                        stall--;
                    end else begin
                        rsp_ready_i = ($urandom_range(0, 3) != 0);
                    end
                    if (rsp_ready_i) begin
                        void'(exp_q.pop_front());
                        chk_idle = 1;
                    end
                end
            end else begin
                rsp_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : driver
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'd0;
        for (int i = 0; i < 4 * DEPTH; i++) ref_mem[i] = 8'd0;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
        mem_rdata_i = 32'd0;
        repeat (3) @(negedge clk_i);
        req_valid_i = 1'b1; req_addr_i = BASE;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_mem_en", 32'(mem_en_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready_o), 32'd1);

        // word store / load
        issue(1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'd0);
        // byte store, signed and unsigned loads
        issue(1'b1, 2'b00, 1'b0, BASE + 32'h13, 32'h0000_0080);
        issue(1'b0, 2'b00, 1'b0, BASE + 32'h13, 32'd0);
        issue(1'b0, 2'b00, 1'b1, BASE + 32'h13, 32'd0);
        // half store / signed load
        issue(1'b1, 2'b01, 1'b0, BASE + 32'h22, 32'h0000_BEEF);
        issue(1'b0, 2'b01, 1'b0, BASE + 32'h22, 32'd0);
        // illegal requests
        issue(1'b0, 2'b01, 1'b0, BASE + 32'h01, 32'd0);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h02, 32'd0);
        issue(1'b0, 2'b11, 1'b0, BASE + 32'h04, 32'd0);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'(4 * DEPTH), 32'd0);
        issue(1'b1, 2'b10, 1'b0, BASE - 32'd4, 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'(4 * DEPTH) - 32'd4, 32'd0);
        drain();

        // held response under back-pressure
        stall_req = 5;
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'd0);
        drain();
        stall_req = 0;

        // async reset while a load is in LOAD_WAIT
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("abort_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("abort_mem_en", 32'(mem_en_o), 32'd0);
        chk("abort_req_ready", 32'(req_ready_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'd0);
        drain();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            r  = int'($urandom_range(0, 9));
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (r == 0)      a = BASE + 32'(4 * DEPTH) + $urandom_range(0, 64);
            else if (r == 1) a = BASE - $urandom_range(1, 64);
            else begin
                a = BASE + ((r < 6) ? $urandom_range(0, 63) : $urandom_range(0, 4 * DEPTH - 1));
                if ($urandom_range(0, 4) != 0) begin
                    if (sz == 2'b01) a[0] = 1'b0;
                    if (sz == 2'b10) a[1:0] = 2'b00;
                end
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
